// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads
// the IF/ID pipeline register. Stops in a sticky fault state when a redirect
// target is misaligned or the PC walks off the end of instruction memory.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc_plus4,
  output logic        o_if_id_valid,
  output logic [31:0] o_fetch_count,
  output logic        o_fault
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PcLimit = 32'(IMEM_WORDS * 4);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;
  logic        r_fault;

  logic [31:0] w_pc_plus4;
  logic        w_redirect_misaligned;
  logic        w_pc_out_of_range;

  assign w_pc_plus4            = r_pc + 32'd4;
  assign w_redirect_misaligned = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  // A redirect target is not range-checked until it becomes the PC.
  assign w_pc_out_of_range     = (r_pc >= PcLimit);

  // PC, IF/ID register, fetch counter and run/halt state, in priority order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= StRun;
      r_pc             <= RESET_PC;
      r_if_id_instr    <= 32'h0;
      r_if_id_pc_plus4 <= 32'h0;
      r_if_id_valid    <= 1'b0;
      r_fetch_count    <= 32'h0;
      r_fault          <= 1'b0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_redirect_misaligned) begin
            r_fault       <= 1'b1;
            r_state       <= StHalt;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
          end else if (i_redirect_valid) begin
            // Redirect outranks stall and flush.
            r_pc          <= i_redirect_pc;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
          end else if (w_pc_out_of_range) begin
            r_fault       <= 1'b1;
            r_state       <= StHalt;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
          end else if (i_stall) begin
            // Hold everything.
          end else if (i_flush) begin
            r_pc          <= w_pc_plus4;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
          end else begin
            r_pc             <= w_pc_plus4;
            r_if_id_instr    <= i_imem_rdata;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
            r_fetch_count    <= r_fetch_count + 32'd1;
          end
        end
        StHalt: begin
          // Only reset leaves HALT; keep feeding bubbles downstream.
          r_if_id_instr <= 32'h0;
          r_if_id_valid <= 1'b0;
        end
        default: begin
          r_state       <= StHalt;
          r_fault       <= 1'b1;
          r_if_id_instr <= 32'h0;
          r_if_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_addr      = r_pc;
  assign o_pc             = r_pc;
  assign o_if_id_instr    = r_if_id_instr;
  assign o_if_id_pc_plus4 = r_if_id_pc_plus4;
  assign o_if_id_valid    = r_if_id_valid;
  assign o_fetch_count    = r_fetch_count;
  assign o_fault          = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized
// stall/flush/redirect/reset traffic, checked against a behavioural model.
module tb_fetch_stage;

  localparam int unsigned Words = 64;
  localparam logic [31:0] Limit = 32'd256;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, pc;
  logic [31:0] if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, fault;

  logic [31:0] mem [Words];

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_fault, m_halted;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return junk.
  assign imem_rdata = (imem_addr < Limit) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  fetch_stage #(
    .RESET_PC  (32'h0),
    .IMEM_WORDS(Words)
  ) u_dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_imem_addr     (imem_addr),
    .i_imem_rdata    (imem_rdata),
    .o_pc            (pc),
    .o_if_id_instr   (if_id_instr),
    .o_if_id_pc_plus4(if_id_pc_plus4),
    .o_if_id_valid   (if_id_valid),
    .o_fetch_count   (fetch_count),
    .o_fault         (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input bit rst, input bit st, input bit fl, input bit rv,
                            input logic [31:0] rpc);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
      m_fault = 0; m_halted = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (rv && rpc[1:0] != 2'b00) begin
      m_fault = 1; m_halted = 1; m_instr = 0; m_valid = 0;
    end else if (rv) begin
      m_pc = rpc; m_instr = 0; m_valid = 0;
    end else if (m_pc >= Limit) begin
      m_fault = 1; m_halted = 1; m_instr = 0; m_valid = 0;
    end else if (st) begin
      // nothing moves
    end else if (fl) begin
      m_instr = 0; m_valid = 0; m_pc = m_pc + 4;
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4   = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
      m_count = m_count + 1;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check("fetch_count", fetch_count, m_count);
    check("fault", {31'b0, fault}, {31'b0, m_fault});
  endtask

  // Drive one cycle of inputs, clock it, then compare away from the edge.
  task automatic cycle(input bit rst, input bit st, input bit fl, input bit rv,
                       input logic [31:0] rpc);
    reset = rst; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    model_step(rst, st, fl, rv, rpc);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    m_fault = 0; m_halted = 0;
    for (int i = 0; i < Words; i++) mem[i] = i + 1;

    // T1: reset then three plain fetches.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("t1_reset_pc", pc, 32'h0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("t1_pc_after2", pc, 32'h8);
    check("t1_instr2", if_id_instr, 32'd2);

    // T2: stall three cycles at pc=8, then resume.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    check("t2_stall_pc", pc, 32'h8);
    check("t2_stall_instr", if_id_instr, 32'd2);
    check("t2_stall_count", fetch_count, 32'd2);
    cycle(0, 0, 0, 0, 0);
    check("t2_resume_instr", if_id_instr, 32'd3);
    check("t2_resume_count", fetch_count, 32'd3);

    // T3: redirect wins over stall.
    cycle(0, 1, 1, 1, 32'h20);
    check("t3_redir_pc", pc, 32'h20);
    check("t3_redir_valid", {31'b0, if_id_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("t3_target_instr", if_id_instr, 32'd9);

    // T4: misaligned redirect faults and halts until reset.
    cycle(0, 0, 0, 1, 32'h22);
    for (int i = 0; i < 4; i++) cycle(0, i[0], 0, i[1], 32'h40);
    check("t4_fault", {31'b0, fault}, 32'd1);
    check("t4_pc_held", pc, 32'h24);
    cycle(1, 0, 0, 0, 0);
    check("t4_reset_fault", {31'b0, fault}, 32'd0);

    // T6: flush at pc=4.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("t6_flush_pc", pc, 32'h8);
    cycle(0, 0, 0, 0, 0);
    check("t6_after_flush", if_id_instr, 32'd3);

    // T5: run off the end of memory.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < Words; i++) cycle(0, 0, 0, 0, 0);
    check("t5_last_instr", if_id_instr, 32'd64);
    check("t5_last_pc4", if_id_pc_plus4, 32'h100);
    cycle(0, 0, 0, 0, 0);
    check("t5_fault", {31'b0, fault}, 32'd1);
    check("t5_pc", pc, 32'h100);

    // Randomized traffic with fresh memory contents.
    for (int i = 0; i < Words; i++) mem[i] = $urandom;
    cycle(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit rst, st, fl, rv;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 6) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {22'b0, 8'($urandom_range(0, 70)), 2'b00};
      if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle(rst, st, fl, rv, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
